frame_buffer_ctrl: RTL and testbench
====================================

Name: frame_buffer_ctrl

Overview:
Parametrised N-way frame buffer controller: 2 to 4 banks, selected as front (displayed) or back (drawn), with no external we/re one-hot select from the client. The drawing engine writes only to the back bank; the VGA scan-out reads only from the front bank. The controller commits bank swaps on the frame boundary, and can hardware-clear the back bank. It sits between the sprite/background renderer and the VGA color mapper.

Parameters:
DATA_W, 4, palette index width per pixel
DEPTH, 307200, pixels per bank (640x480)
ADDR_W, 19, address width; must satisfy 2^ADDR_W >= DEPTH
NUM_BUF, 2, bank count, legal 2..4
CLEAR_VAL, 0, DATA_W value written by hardware clear

Ports:
Clk  in  1  system clock
Reset  in  1  asynchronous, active-high reset
wr_en  in  1  renderer write strobe
wr_addr  in  ADDR_W  renderer pixel address
wr_data  in  DATA_W  renderer pixel value
wr_ready  out  1  write accepted this cycle when high
rd_en  in  1  scan-out read strobe
rd_addr  in  ADDR_W  scan-out pixel address
rd_data  out  DATA_W  front-bank pixel, registered
rd_valid  out  1  rd_data valid (rd_en delayed 1 cycle)
frame_start  in  1  one-cycle pulse at vsync / start of frame
swap_req  in  1  one-cycle pulse: renderer finished back frame
swap_ack  out  1  one-cycle pulse in the cycle a swap commits
clear_req  in  1  one-cycle pulse: fill back bank with CLEAR_VAL
clear_done  out  1  one-cycle pulse after the last clear write
front_idx  out  2  current front bank index
back_idx  out  2  current back bank index

Behaviour:
- Reset values: front_idx=0, back_idx=1, rd_data=0, rd_valid=0, swap_ack=0, clear_done=0, swap_pending=0, state=IDLE, clear counter=0.
- Read path:
  - Latency 1: rd_data <= bank[front_idx][rd_addr] when rd_en; rd_valid <= rd_en.
  - rd_data holds its value when rd_en=0.
  - A read in the swap-commit cycle uses the old front_idx.
- Write path: when wr_en && wr_ready, bank[back_idx][wr_addr] <= wr_data. Writes while wr_ready=0 are dropped with no side effect.
- Address range: addresses >= DEPTH are ignored for writes and return 0 for reads.
- FSM states:
  - IDLE: wr_ready = !swap_pending.
  - CLEAR: wr_ready=0; one write per cycle at cnt, cnt counts 0..DEPTH-1. At cnt==DEPTH-1, pulse clear_done next cycle and go to IDLE.
  - WAIT_SWAP: entered from IDLE on swap_req; wr_ready=0.
- swap_pending:
  - Set on swap_req in IDLE or CLEAR.
  - A swap_req while already pending is ignored.
- Commit:
  - Condition: frame_start && (swap_pending || swap_req) && state!=CLEAR.
  - Updates: front_idx <= back_idx; back_idx <= (back_idx+1) mod NUM_BUF; clear pending; swap_ack=1 for one cycle; go to IDLE.
  - swap_req and frame_start in the same cycle commit immediately.
- Swap requested during CLEAR: stays pending. Commit only on the first frame_start after clear_done.
- clear_req:
  - Accepted only in IDLE with swap_pending=0; otherwise ignored.
  - Simultaneous clear_req and swap_req in IDLE: swap_req wins and clear_req is dropped.
- Reset mid-CLEAR or mid-WAIT_SWAP: immediate return to reset values. Bank contents are undefined (not cleared).
- NUM_BUF=2 reduces to classic ping-pong, front/back = {0,1}/{1,0}.

Decomposition:
- Shared package fb_pkg:
  - fb_state_t enum {IDLE, CLEAR, WAIT_SWAP}
  - bank index type logic [1:0]
  - screen constants H_RES=640, V_RES=480
- One sub-module, frame_buffer_bank:
  - Single synchronous-write, registered-read RAM (DATA_W x DEPTH).
  - Instantiated NUM_BUF times via generate.
  - Controller decodes per-bank WE/RE from front_idx/back_idx.

Test Plan:
1. Reset, then write addr 5 = 4'hA, then read addr 5 → rd_data=0, rd_valid=1 one cycle after rd_en (front bank 0 untouched). swap_req, then frame_start 3 cycles later → swap_ack pulse, front_idx=1. Re-read addr 5 → 4'hA.
2. swap_req, then write addr 7 = 4'h3 before frame_start → wr_ready=0, write dropped. After commit, addr 7 in new back bank unchanged.
3. NUM_BUF=3, three swap cycles → front_idx sequence 1,2,0 and back_idx 2,0,1.
4. clear_req with DEPTH=16 → wr_ready=0 for 16 cycles, clear_done pulse on cycle 17. All 16 back-bank words = CLEAR_VAL after swap.
5. swap_req mid-CLEAR with frame_start during CLEAR → no swap_ack. Next frame_start after clear_done → swap_ack.
6. swap_req and frame_start in the same cycle → swap_ack that cycle+1. Assert Reset mid-CLEAR (cnt=8) → front_idx=0, back_idx=1, clear_done never pulses.

Source files
------------

// File: rtl/fb_pkg.sv
// rtl/fb_pkg.sv - shared types and constants for the frame buffer controller
package fb_pkg;
  typedef enum logic [1:0] {IDLE, CLEAR, WAIT_SWAP} fb_state_t;
  typedef logic [1:0] bank_idx_t;

  localparam int H_RES = 640;
  localparam int V_RES = 480;

  // Round-robin successor of a bank index over num_buf banks.
  function automatic bank_idx_t next_idx(input bank_idx_t idx, input int num_buf);
    return (int'(idx) == num_buf - 1) ? 2'd0 : idx + 2'd1;
  endfunction
endpackage

// File: rtl/frame_buffer_bank.sv
// rtl/frame_buffer_bank.sv - one pixel bank: synchronous write, registered read
module frame_buffer_bank #(
  parameter int DATA_W = 4,
  parameter int DEPTH  = 307200,
  parameter int ADDR_W = 19
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic w_in_range, r_in_range;

  assign w_in_range = {1'b0, waddr} < LIMIT;
  assign r_in_range = {1'b0, raddr} < LIMIT;

  always_ff @(posedge clk) begin
    if (we && w_in_range) mem[waddr[IW-1:0]] <= wdata;
  end

  // Out-of-range reads return zero rather than an aliased pixel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (re) rdata <= r_in_range ? mem[raddr[IW-1:0]] : '0;
  end
endmodule

// File: rtl/frame_buffer_ctrl.sv
// rtl/frame_buffer_ctrl.sv - N-way front/back frame buffer with vsync-aligned swap and hardware clear
module frame_buffer_ctrl
  import fb_pkg::*;
#(
  parameter int              DATA_W    = 4,
  parameter int              DEPTH     = H_RES * V_RES,
  parameter int              ADDR_W    = 19,
  parameter int              NUM_BUF   = 2,
  parameter logic [DATA_W-1:0] CLEAR_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              frame_start,
  input  logic              swap_req,
  output logic              swap_ack,
  input  logic              clear_req,
  output logic              clear_done,
  output bank_idx_t         front_idx,
  output bank_idx_t         back_idx
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  fb_state_t         state;
  logic              swap_pending;
  logic [ADDR_W-1:0] cnt;
  bank_idx_t         rd_sel;
  logic              clearing, commit, wen_any;
  logic [ADDR_W-1:0] bank_waddr;
  logic [DATA_W-1:0] bank_wdata;
  logic [NUM_BUF-1:0] bank_we, bank_re;
  logic [DATA_W-1:0] bank_rdata [NUM_BUF];

  assign clearing   = (state == CLEAR);
  assign wr_ready   = (state == IDLE) && !swap_pending;
  assign commit     = frame_start && (swap_pending || swap_req) && !clearing;
  assign wen_any    = clearing || (wr_en && wr_ready);
  assign bank_waddr = clearing ? cnt : wr_addr;
  assign bank_wdata = clearing ? CLEAR_VAL : wr_data;

  for (genvar g = 0; g < NUM_BUF; g++) begin : g_bank
    assign bank_we[g] = wen_any && (back_idx == bank_idx_t'(g));
    assign bank_re[g] = rd_en && (front_idx == bank_idx_t'(g));
    frame_buffer_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (bank_we[g]),
      .waddr (bank_waddr),
      .wdata (bank_wdata),
      .re    (bank_re[g]),
      .raddr (rd_addr),
      .rdata (bank_rdata[g])
    );
  end

  // rd_sel remembers which bank served the last read, so a later swap cannot change rd_data.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_BUF; i++) begin
      if (rd_sel == bank_idx_t'(i)) rd_data = bank_rdata[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      swap_pending <= 1'b0;
      cnt          <= '0;
      front_idx    <= 2'd0;
      back_idx     <= 2'd1;
      swap_ack     <= 1'b0;
      clear_done   <= 1'b0;
      rd_valid     <= 1'b0;
      rd_sel       <= 2'd0;
    end else begin
      swap_ack   <= 1'b0;
      clear_done <= 1'b0;
      rd_valid   <= rd_en;
      if (rd_en) rd_sel <= front_idx;

      if (commit) begin
        front_idx    <= back_idx;
        back_idx     <= next_idx(back_idx, NUM_BUF);
        swap_pending <= 1'b0;
        swap_ack     <= 1'b1;
        state        <= IDLE;
      end else begin
        case (state)
          IDLE: begin
            if (swap_req && !swap_pending) begin
              swap_pending <= 1'b1;
              state        <= WAIT_SWAP;
            end else if (clear_req && !swap_pending && !swap_req) begin
              cnt   <= '0;
              state <= CLEAR;
            end
          end
          CLEAR: begin
            if (swap_req) swap_pending <= 1'b1;
            if (cnt == LAST) begin
              cnt        <= '0;
              clear_done <= 1'b1;
              state      <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WAIT_SWAP: state <= WAIT_SWAP;
          default:   state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_frame_buffer_ctrl.sv
// tb/tb_frame_buffer_ctrl.sv - directed bench with read scoreboard for frame_buffer_ctrl
module tb_frame_buffer_ctrl;
  localparam int DW = 4;
  localparam int DEP = 16;
  localparam int AW = 5;
  localparam logic [DW-1:0] CV = 4'h5;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en, rd_en, frame_start, swap_req, clear_req;
  logic [AW-1:0] wr_addr, rd_addr;
  logic [DW-1:0] wr_data, rd_data;
  logic          wr_ready, rd_valid, swap_ack, clear_done;
  logic [1:0]    front_idx, back_idx;

  logic          f3, s3;
  logic [DW-1:0] rd_data3;
  logic          wr_ready3, rd_valid3, swap_ack3, clear_done3;
  logic [1:0]    front3, back3;

  frame_buffer_ctrl #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .NUM_BUF(2), .CLEAR_VAL(CV)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_ready(wr_ready), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .frame_start(frame_start), .swap_req(swap_req),
    .swap_ack(swap_ack), .clear_req(clear_req), .clear_done(clear_done),
    .front_idx(front_idx), .back_idx(back_idx)
  );

  frame_buffer_ctrl #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .NUM_BUF(3), .CLEAR_VAL(CV)) dut3 (
    .clk(clk), .rst(rst), .wr_en(1'b0), .wr_addr(5'd0), .wr_data(4'd0),
    .wr_ready(wr_ready3), .rd_en(1'b0), .rd_addr(5'd0), .rd_data(rd_data3),
    .rd_valid(rd_valid3), .frame_start(f3), .swap_req(s3),
    .swap_ack(swap_ack3), .clear_req(1'b0), .clear_done(clear_done3),
    .front_idx(front3), .back_idx(back3)
  );

  int passed = 0;
  int total = 0;
  logic [DW-1:0] mdl [2][DEP];
  logic [DW-1:0] exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mdl(input int b);
    for (int i = 0; i < DEP; i++) mdl[b][i] = CV;
  endtask

  task automatic do_read(input logic [AW-1:0] a, input int b);
    rd_en = 1'b1;
    rd_addr = a;
    exp_q.push_back((a < AW'(DEP)) ? mdl[b][a[3:0]] : 4'h0);
    step();
    rd_en = 1'b0;
    chk("rd_valid", rd_valid, 1);
    chk("rd_data", rd_data, exp_q.pop_front());
  endtask

  task automatic wait_clear_done(output int n);
    n = 0;
    while (clear_done !== 1'b1 && n < 40) begin
      step();
      n++;
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int low;
    logic seen;
    logic [1:0] fr_exp [3];
    logic [1:0] bk_exp [3];
    fr_exp[0] = 2'd1; fr_exp[1] = 2'd2; fr_exp[2] = 2'd0;
    bk_exp[0] = 2'd2; bk_exp[1] = 2'd0; bk_exp[2] = 2'd1;
    wr_en = 0; rd_en = 0; frame_start = 0; swap_req = 0; clear_req = 0;
    wr_addr = '0; rd_addr = '0; wr_data = '0; f3 = 0; s3 = 0;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;

    chk("rst_front", front_idx, 0);
    chk("rst_back", back_idx, 1);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_swap_ack", swap_ack, 0);
    chk("rst_clear_done", clear_done, 0);
    chk("rst_wr_ready", wr_ready, 1);
    chk("rst_front3", front3, 0);
    chk("rst_back3", back3, 1);

    // Hardware clear of bank 1: 16 busy cycles, clear_done on the 17th
    clear_req = 1; step(); clear_req = 0;
    low = 0;
    for (int i = 0; i < DEP; i++) begin
      if (wr_ready === 1'b0 && clear_done === 1'b0) low++;
      step();
    end
    chk("clear_busy_cycles", low, 16);
    chk("clear_done_pulse", clear_done, 1);
    chk("clear_wr_ready_back", wr_ready, 1);
    step();
    chk("clear_done_one_cycle", clear_done, 0);
    clear_mdl(1);

    swap_req = 1; step(); swap_req = 0;
    chk("wait_swap_wr_ready", wr_ready, 0);
    step(); step();
    frame_start = 1; step(); frame_start = 0;
    chk("swap1_ack", swap_ack, 1);
    chk("swap1_front", front_idx, 1);
    chk("swap1_back", back_idx, 0);
    step();
    chk("swap1_ack_low", swap_ack, 0);

    clear_req = 1; step(); clear_req = 0;
    wait_clear_done(n);
    chk("clear0_len", n, 16);
    clear_mdl(0);

    // Write during WAIT_SWAP is dropped
    swap_req = 1; step(); swap_req = 0;
    wr_en = 1; wr_addr = 5'd7; wr_data = 4'h3;
    chk("drop_wr_ready", wr_ready, 0);
    step(); wr_en = 0;
    step();
    frame_start = 1; step(); frame_start = 0;
    chk("swap2_ack", swap_ack, 1);
    chk("swap2_front", front_idx, 0);
    chk("swap2_back", back_idx, 1);
    step();
    do_read(5'd7, 0);

    wr_en = 1; wr_addr = 5'd5; wr_data = 4'hA;
    chk("t1_wr_ready", wr_ready, 1);
    step(); wr_en = 0;
    mdl[1][5] = 4'hA;
    do_read(5'd5, 0);
    swap_req = 1; step(); swap_req = 0;
    step(); step();
    frame_start = 1; step(); frame_start = 0;
    chk("t1_ack", swap_ack, 1);
    chk("t1_front", front_idx, 1);
    step();
    do_read(5'd5, 1);
    step();
    chk("hold_rd_valid", rd_valid, 0);
    chk("hold_rd_data", rd_data, 4'hA);
    do_read(5'd20, 1);

    // Out-of-range write to back bank 0 must not alias onto address 5
    wr_en = 1; wr_addr = 5'd21; wr_data = 4'h9; step(); wr_en = 0;

    // Read in the commit cycle sees the old front bank
    rd_en = 1; rd_addr = 5'd5; swap_req = 1; frame_start = 1;
    exp_q.push_back(mdl[1][5]);
    step();
    rd_en = 0; swap_req = 0; frame_start = 0;
    chk("same_cycle_ack", swap_ack, 1);
    chk("same_cycle_front", front_idx, 0);
    chk("same_cycle_back", back_idx, 1);
    chk("commit_rd_valid", rd_valid, 1);
    chk("commit_rd_data", rd_data, exp_q.pop_front());
    step();
    chk("same_cycle_ack_low", swap_ack, 0);
    do_read(5'd5, 0);

    // Swap requested mid-clear waits for clear_done
    clear_req = 1; step(); clear_req = 0;
    step(); step();
    swap_req = 1; frame_start = 1; step(); swap_req = 0; frame_start = 0;
    chk("midclear_no_ack1", swap_ack, 0);
    chk("midclear_front", front_idx, 0);
    step();
    frame_start = 1; step(); frame_start = 0;
    chk("midclear_no_ack2", swap_ack, 0);
    wait_clear_done(n);
    chk("midclear_done_seen", clear_done, 1);
    clear_mdl(1);
    chk("pending_wr_ready", wr_ready, 0);
    clear_req = 1; step(); clear_req = 0;
    frame_start = 1; step(); frame_start = 0;
    chk("post_clear_ack", swap_ack, 1);
    chk("post_clear_front", front_idx, 1);
    chk("post_clear_back", back_idx, 0);
    step();
    for (int i = 0; i < DEP; i++) do_read(AW'(i), 1);

    // swap_req beats simultaneous clear_req
    clear_req = 1; swap_req = 1; step(); clear_req = 0; swap_req = 0;
    chk("swap_wins_wr_ready", wr_ready, 0);
    frame_start = 1; step(); frame_start = 0;
    chk("swap_wins_ack", swap_ack, 1);
    chk("swap_wins_front", front_idx, 0);

    swap_req = 1; frame_start = 1; step(); swap_req = 0; frame_start = 0;
    chk("pre_rst_front", front_idx, 1);

    // Reset in the middle of a clear
    clear_req = 1; step(); clear_req = 0;
    repeat (8) step();
    rst = 1; #1;
    chk("midrst_front", front_idx, 0);
    chk("midrst_back", back_idx, 1);
    chk("midrst_clear_done", clear_done, 0);
    step();
    rst = 0;
    seen = 1'b0;
    repeat (24) begin
      seen = seen | clear_done;
      step();
    end
    chk("midrst_never_done", seen, 0);
    chk("midrst_wr_ready", wr_ready, 1);

    // Three-bank rotation
    for (int k = 0; k < 3; k++) begin
      s3 = 1; f3 = 1; step(); s3 = 0; f3 = 0;
      chk("nb3_front", front3, fr_exp[k]);
      chk("nb3_back", back3, bk_exp[k]);
      chk("nb3_ack", swap_ack3, 1);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
